// File: rtl/bitty_fetch_unit_pkg.sv
// Shared definitions for the bitty fetch unit: the instruction width, the
// default halt word and the fetch FSM state encoding.
package bitty_fetch_unit_pkg;

    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        ISSUE    = 3'd3,
        EXEC     = 3'd4,
        HALT     = 3'd5
    } fetch_state_t;

    // Busy covers every state in which a program is in flight.
    function automatic logic state_is_busy(input fetch_state_t s);
        return !((s == IDLE) || (s == HALT));
    endfunction

endpackage

// File: rtl/bitty_fetch_watchdog.sv
// bitty_fetch_watchdog: EXEC-phase watchdog for the fetch unit.
// Down-counter loaded with TIMEOUT_CYC-1 on the way into EXEC and decremented
// once per EXEC cycle; expired flags the EXEC cycle that completes
// TIMEOUT_CYC cycles without the counter being reloaded.
module bitty_fetch_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on EXEC entry, count down while in EXEC, park at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (count_en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = count_en && (cnt == '0);

endmodule

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: fetches 16-bit instructions from a synchronous
// instruction memory, presents each one to the core with a one-cycle run
// pulse and waits for done before fetching the next. A fetched HALT_WORD
// ends the program without being issued.
// Optional build: define BITTY_FETCH_TIMEOUT_EN to add the EXEC watchdog
// (bitty_fetch_watchdog) and the sticky timeout output.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | out of reset, waiting for start
// FETCH    | read strobe issued at pc
// WAIT_MEM | read data returns; halt-word check and instruction capture
// ISSUE    | run pulse to the core
// EXEC     | waiting for done (or watchdog expiry when compiled in)
// HALT     | program ended, waiting for start to rerun from address 0
module bitty_fetch_unit
    import bitty_fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W      = 8,
    parameter logic [INSTR_W-1:0] HALT_WORD   = HALT_WORD_DEFAULT,
    parameter int                 TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               run,
    input  logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
`ifdef BITTY_FETCH_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    // A zero watchdog period would halt before the core ever sees EXEC.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("bitty_fetch_unit: TIMEOUT_CYC must be at least 1");
    end

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_nxt;
    logic               start_accepted;
    logic               wd_expired;

    assign start_accepted = start && !state_is_busy(state);

    // State, program counter and issued-instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
        end
    end

    // Next-state, pc advance and instruction capture.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt = FETCH;
                    pc_nxt    = '0;
                end
            end
            FETCH: begin
                state_nxt = WAIT_MEM;
            end
            WAIT_MEM: begin
                // The halt word is never latched, so the last issued
                // instruction stays visible while halted.
                if (mem_rdata == HALT_WORD) begin
                    state_nxt = HALT;
                end else begin
                    instr_nxt = mem_rdata;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                // done wins over a watchdog expiry in the same cycle.
                if (done) begin
                    pc_nxt    = pc_q + ADDR_W'(1);
                    state_nxt = FETCH;
                end else if (wd_expired) begin
                    state_nxt = HALT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef BITTY_FETCH_TIMEOUT_EN
    logic wd_load;
    logic wd_count;
    logic timeout_q;

    // ISSUE always leads to EXEC, so loading there clears the count on entry.
    assign wd_load  = (state == ISSUE);
    assign wd_count = (state == EXEC);

    bitty_fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    // Sticky timeout flag: set on watchdog halt, cleared by the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (start_accepted) begin
            timeout_q <= 1'b0;
        end else if ((state == EXEC) && !done && wd_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expired = 1'b0;
`endif

    assign mem_rd_en   = (state == FETCH);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign run         = (state == ISSUE);
    assign busy        = state_is_busy(state);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Testbench for bitty_fetch_unit: randomized programs against a
// behavioural program-walk model feeding a scoreboard; a monitor checks
// every run pulse (address, instruction, latency, spacing).
`timescale 1ns/1ps
module tb_bitty_fetch_unit;

    localparam int          AW     = 4;
    localparam int          DEPTH  = 1 << AW;
    localparam logic [15:0] HALT_W = 16'hFFFF;
    localparam int          TMO    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic          mem_rd_en;
    logic          run;
    logic          busy;
    logic          halted;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] pc;
    logic [15:0]   mem_rdata = 16'h0;
    logic [15:0]   instruction;
`ifdef BITTY_FETCH_TIMEOUT_EN
    logic          timeout;
`endif

    bitty_fetch_unit #(
        .ADDR_W      (AW),
        .HALT_WORD   (HALT_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .run         (run),
        .done        (done),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
`ifdef BITTY_FETCH_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous instruction memory; garbage on cycles without a read.
    logic [15:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= 16'($urandom);
    end

    typedef struct {
        int          addr;
        logic [15:0] instr;
        bit          first;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   run_count = 0;
    int   start_cyc = 0;
    int   first_done = -1;
    int   last_run_cyc = 0;
    bit   prev_run = 1'b0;

    int done_mode = 0;    // 0: one done per run after a delay, 1: done held high
    int quota = 0;        // runs the responder will still answer
    int fixed_dly = -1;   // <0: random 0..3 extra cycles
    int resp_dly;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == HALT_W) w = 16'h0000;
        return w;
    endfunction

    // Reference model: walk memory from 0, stop at the halt word.
    task automatic expect_program(input int max_items, output int n, output int end_pc);
        int   a;
        exp_t e;
        a = 0;
        n = 0;
        while (n < max_items && mem[AW'(a)] != HALT_W) begin
            e.addr  = a;
            e.instr = mem[AW'(a)];
            e.first = (n == 0);
            sb.push_back(e);
            n++;
            a = (a + 1) % DEPTH;
        end
        end_pc = a;
    endtask

    // Monitor: every run pulse is checked against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            if (run) begin
                check("run_spacing", 32'(prev_run), 32'd0);
                run_count++;
                last_run_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_run", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("run_pc", 32'(pc), 32'(cur.addr));
                    check("run_instr", 32'(instruction), 32'(cur.instr));
                    check("run_busy", 32'(busy), 32'd1);
                    if (cur.first)
                        check("start_to_run_latency", 32'(cyc - start_cyc), 32'd3);
                    else if (first_done < 0)
                        check("run_without_done", 32'd1, 32'd0);
                    else
                        check("done_to_run_latency", 32'(cyc - first_done), 32'd3);
                end
                first_done = -1;
            end else if (done && first_done < 0) begin
                first_done = cyc;
            end
        end
        prev_run = run;
    end

    // Core model: answer each run with one done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (run && done_mode == 0 && quota > 0) begin
                quota--;
                resp_dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                repeat (resp_dly + 1) @(posedge clk);
                #1 done = 1'b1;
                @(posedge clk);
                #1 done = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_runs(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (run_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(run_count >= target), 32'd1);
    endtask

    task automatic fill_program(input int len);
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        mem[AW'(len)] = HALT_W;
    endtask

    task automatic run_program(input string tag);
        int n, end_pc, base;
        expect_program(DEPTH, n, end_pc);
        base = run_count;
        pulse_start();
        wait_halt({tag, "_halt"}, 40 * (n + 2));
        check({tag, "_pc"}, 32'(pc), 32'(end_pc));
        check({tag, "_runs"}, 32'(run_count - base), 32'(n));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int n, end_pc, base, busy_lo, len;

        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
`ifdef BITTY_FETCH_TIMEOUT_EN
        check("rst_timeout", 32'(timeout), 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;
        done = 1'b1;
        repeat (5) @(negedge clk);
        done = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rd_en", 32'(mem_rd_en), 32'd0);
        check("idle_halted", 32'(halted), 32'd0);

        // Fixed two-instruction program, done two cycles after each run.
        fill_program(2);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        quota = 100;
        fixed_dly = 1;
        run_program("basic");

        // done held high throughout, including ISSUE.
        fill_program(4);
        done_mode = 1;
        #1 done = 1'b1;
        run_program("done_held");
        done_mode = 0;
        done = 1'b0;

        // Random programs, first one halts at address 0.
        fixed_dly = -1;
        for (int t = 0; t < 5; t++) begin
            len = (t == 0) ? 0 : int'($urandom_range(1, 8));
            fill_program(len);
            quota = 100;
            run_program("rand_prog");
        end

        // start pulsed during EXEC must be ignored.
        fill_program(3);
        quota = 100;
        fixed_dly = 3;
        expect_program(DEPTH, n, end_pc);
        base = run_count;
        pulse_start();
        wait_runs("exec_first_run", base + 1, 20);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("exec_start_pc", 32'(pc), 32'd0);
        check("exec_start_busy", 32'(busy), 32'd1);
        wait_halt("exec_start_halt", 100);
        check("exec_start_runs", 32'(run_count - base), 32'(n));
        check("exec_start_end_pc", 32'(pc), 32'(end_pc));
        sb.delete();

        // No halt word: pc wraps, then reset lands mid-EXEC at pc 5.
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        fixed_dly = -1;
        quota = 21;
        expect_program(22, n, end_pc);
        base = run_count;
        busy_lo = 0;
        pulse_start();
        for (int k = 0; k < 400 && run_count < base + 22; k++) begin
            @(negedge clk);
            if (!busy) busy_lo++;
        end
        check("wrap_runs", 32'(run_count - base), 32'd22);
        check("wrap_busy_low_cycles", 32'(busy_lo), 32'd0);
        repeat (3) @(negedge clk);
        check("wrap_pc_in_exec", 32'(pc), 32'd5);
        check("wrap_busy", 32'(busy), 32'd1);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midexec_rst_pc", 32'(pc), 32'd0);
        check("midexec_rst_run", 32'(run), 32'd0);
        check("midexec_rst_busy", 32'(busy), 32'd0);
        check("midexec_rst_halted", 32'(halted), 32'd0);
        check("midexec_rst_instr", 32'(instruction), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        fill_program(2);
        quota = 100;
        run_program("after_reset");

`ifdef BITTY_FETCH_TIMEOUT_EN
        // Watchdog: no done at all, HALT four EXEC cycles after entry.
        fill_program(1);
        quota = 0;
        expect_program(DEPTH, n, end_pc);
        base = run_count;
        pulse_start();
        wait_runs("tmo_run", base + 1, 20);
        wait_halt("tmo_halt", 40);
        check("tmo_halt_latency", 32'(cyc - last_run_cyc), 32'(1 + TMO));
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_pc", 32'(pc), 32'd0);
        sb.delete();
        quota = 100;
        expect_program(DEPTH, n, end_pc);
        pulse_start();
        check("tmo_cleared", 32'(timeout), 32'd0);
        wait_halt("tmo_rerun_halt", 100);
        check("tmo_rerun_pc", 32'(pc), 32'(end_pc));
        check("tmo_rerun_flag", 32'(timeout), 32'd0);
        sb.delete();
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
